// File: rtl/i2c_slave_regfile_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_regfile_if
//
// Groups the signals between i2c_slave_regfile and its surroundings:
//   I2C pads : scl_i, sda_i (asynchronous pad inputs), sda_oe (1 = pull SDA low)
//   status   : busy (target addressed and transaction in progress)
//   host port: host_we, host_addr, host_wdata, host_rdata (registered read)
//   write log: wr_stb, wr_addr, wr_data (one pulse per byte written over I2C)
//
// Modports:
//   slave  - the register-file target (drives sda_oe, busy, host_rdata, wr_*)
//   master - the environment (drives pads and the host port)
//
// Parameter ADDR_W must match the ADDR_W of the attached i2c_slave_regfile.
// ---------------------------------------------------------------------------
interface i2c_slave_regfile_if #(
   parameter int ADDR_W = 4
);
   logic              scl_i;
   logic              sda_i;
   logic              sda_oe;
   logic              busy;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [7:0]        host_wdata;
   logic [7:0]        host_rdata;
   logic              wr_stb;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport slave (
      input  scl_i,
      input  sda_i,
      input  host_we,
      input  host_addr,
      input  host_wdata,
      output sda_oe,
      output busy,
      output host_rdata,
      output wr_stb,
      output wr_addr,
      output wr_data
   );

   modport master (
      output scl_i,
      output sda_i,
      output host_we,
      output host_addr,
      output host_wdata,
      input  sda_oe,
      input  busy,
      input  host_rdata,
      input  wr_stb,
      input  wr_addr,
      input  wr_data
   );
endinterface

// File: rtl/i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// i2c_slave_regfile
//
// I2C target with a byte-wide register file of DEPTH = 2**ADDR_W entries,
// oversampled from clk (clk must be at least 16x the SCL frequency).
// Supports multi-byte writes/reads with pointer auto-increment, repeated
// START, address filtering and master NACK handling. Local logic reads and
// writes the same register file through the host port.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - i2c_slave_regfile_if.slave:
//          scl_i, sda_i     asynchronous pad inputs
//          sda_oe           1 = drive SDA low (open-drain pad)
//          busy             addressed START until STOP / address mismatch
//          host_we/addr/wdata, host_rdata (1 clk registered read)
//          wr_stb/wr_addr/wr_data  one-clk pulse per byte written over I2C
//
// Parameters:
//   SLAVE_ADDR - 7-bit target address (default 7'h50)
//   ADDR_W     - register pointer width (default 4, must be <= 8)
//
// Build option:
//   I2C_SLAVE_GCALL_EN - when defined, the general-call address byte 8'h00
//   is acknowledged and treated as a normal write. 8'h01 is never ACKed.
// ---------------------------------------------------------------------------
module i2c_slave_regfile #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         ADDR_W     = 4
) (
   input logic                clk,
   input logic                rst,
   i2c_slave_regfile_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WRITE,
      ST_WRITE_ACK,
      ST_READ,
      ST_MACK,
      ST_IGNORE
   } state_t;

   // Input conditioning: two synchroniser flops plus one edge-detect stage
   logic scl_s1_reg, scl_s2_reg, scl_s3_reg;
   logic sda_s1_reg, sda_s2_reg, sda_s3_reg;

   logic              scl_rise;
   logic              scl_fall;
   logic              start_det;
   logic              stop_det;
   logic              byte_done;
   logic              addr_hit;
   logic              i2c_we;
   logic [7:0]        rx_byte;
   logic [ADDR_W-1:0] ptr_inc;

   state_t            state_reg;
   logic [2:0]        bit_cnt_reg;
   logic [6:0]        shreg_reg;
   logic [7:0]        rd_shift_reg;
   logic              rw_reg;
   logic [ADDR_W-1:0] ptr_reg;
   logic              sda_oe_reg;
   logic              busy_reg;
   logic              wr_stb_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic [7:0]        wr_data_reg;
   logic [7:0]        host_rdata_reg;

   logic [7:0]        regfile [DEPTH];

   // Synchronisers idle high so reset does not manufacture a bus edge
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_s1_reg <= 1'b1;
         scl_s2_reg <= 1'b1;
         scl_s3_reg <= 1'b1;
         sda_s1_reg <= 1'b1;
         sda_s2_reg <= 1'b1;
         sda_s3_reg <= 1'b1;
      end else begin
         scl_s1_reg <= bus.scl_i;
         scl_s2_reg <= scl_s1_reg;
         scl_s3_reg <= scl_s2_reg;
         sda_s1_reg <= bus.sda_i;
         sda_s2_reg <= sda_s1_reg;
         sda_s3_reg <= sda_s2_reg;
      end
   end

   assign scl_rise  =  scl_s2_reg & ~scl_s3_reg;
   assign scl_fall  = ~scl_s2_reg &  scl_s3_reg;
   // SDA may only move while SCL is low, so any SDA edge with SCL high
   // on both sampled stages is a bus condition.
   assign start_det =  scl_s2_reg & scl_s3_reg &  sda_s3_reg & ~sda_s2_reg;
   assign stop_det  =  scl_s2_reg & scl_s3_reg & ~sda_s3_reg &  sda_s2_reg;

   // Byte as it will look after the bit sampled on this scl_rise is shifted in
   assign rx_byte   = {shreg_reg, sda_s2_reg};
   assign byte_done = scl_rise && (bit_cnt_reg == 3'd7);
   assign ptr_inc   = ptr_reg + 1'b1;

`ifdef I2C_SLAVE_GCALL_EN
   assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR) || (rx_byte == 8'h00);
`else
   assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR);
`endif

   // The I2C write lands in the same clk that wr_stb is registered, so a
   // host read issued during the wr_stb clk already sees the new value.
   assign i2c_we = (state_reg == ST_WRITE) && byte_done;

   // -----------------------------------------------------------------------
   // Protocol FSM. In every *_ACK state sda_oe_reg doubles as the phase
   // flag: the first scl_fall (end of bit 8) starts driving the ACK, the
   // second scl_fall (end of the ACK bit) ends it.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         bit_cnt_reg  <= 3'd0;
         shreg_reg    <= 7'd0;
         rd_shift_reg <= 8'h00;
         rw_reg       <= 1'b0;
         ptr_reg      <= '0;
         sda_oe_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         wr_stb_reg   <= 1'b0;
         wr_addr_reg  <= '0;
         wr_data_reg  <= 8'h00;
      end else begin
         wr_stb_reg <= 1'b0;
         if (scl_rise) begin
            shreg_reg <= rx_byte[6:0];
         end

         if (start_det) begin
            state_reg   <= ST_ADDR;
            bit_cnt_reg <= 3'd0;
            sda_oe_reg  <= 1'b0;
         end else if (stop_det) begin
            state_reg  <= ST_IDLE;
            busy_reg   <= 1'b0;
            sda_oe_reg <= 1'b0;
         end else begin
            if (state_reg == ST_ADDR_ACK) begin
               busy_reg <= 1'b1;
            end else if (state_reg == ST_IGNORE || state_reg == ST_IDLE) begin
               busy_reg <= 1'b0;
            end

            case (state_reg)
               ST_IDLE: begin
                  sda_oe_reg <= 1'b0;
               end

               ST_ADDR: begin
                  if (scl_rise) begin
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     if (byte_done) begin
                        if (addr_hit) begin
                           state_reg    <= ST_ADDR_ACK;
                           rw_reg       <= rx_byte[0];
                           rd_shift_reg <= regfile[ptr_reg];
                        end else begin
                           state_reg <= ST_IGNORE;
                        end
                     end
                  end
               end

               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe_reg) begin
                        sda_oe_reg <= 1'b1;
                     end else if (rw_reg) begin
                        // ACK ends and the first data bit goes out on the same fall
                        state_reg    <= ST_READ;
                        sda_oe_reg   <= ~rd_shift_reg[7];
                        rd_shift_reg <= {rd_shift_reg[6:0], 1'b0};
                     end else begin
                        state_reg  <= ST_PTR;
                        sda_oe_reg <= 1'b0;
                     end
                  end
               end

               ST_PTR: begin
                  if (scl_rise) begin
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     if (byte_done) begin
                        ptr_reg   <= rx_byte[ADDR_W-1:0];
                        state_reg <= ST_PTR_ACK;
                     end
                  end
               end

               ST_PTR_ACK, ST_WRITE_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe_reg) begin
                        sda_oe_reg <= 1'b1;
                     end else begin
                        sda_oe_reg <= 1'b0;
                        state_reg  <= ST_WRITE;
                     end
                  end
               end

               ST_WRITE: begin
                  if (scl_rise) begin
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     if (byte_done) begin
                        wr_stb_reg  <= 1'b1;
                        wr_addr_reg <= ptr_reg;
                        wr_data_reg <= rx_byte;
                        ptr_reg     <= ptr_inc;
                        state_reg   <= ST_WRITE_ACK;
                     end
                  end
               end

               ST_READ: begin
                  if (scl_fall) begin
                     sda_oe_reg   <= ~rd_shift_reg[7];
                     rd_shift_reg <= {rd_shift_reg[6:0], 1'b0};
                  end
                  if (scl_rise) begin
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     if (byte_done) begin
                        state_reg <= ST_MACK;
                     end
                  end
               end

               ST_MACK: begin
                  // Release SDA for the master's ACK bit
                  if (scl_fall) begin
                     sda_oe_reg <= 1'b0;
                  end
                  if (scl_rise) begin
                     if (!sda_s2_reg) begin
                        ptr_reg      <= ptr_inc;
                        rd_shift_reg <= regfile[ptr_inc];
                        state_reg    <= ST_READ;
                     end else begin
                        state_reg <= ST_IGNORE;
                     end
                  end
               end

               ST_IGNORE: begin
                  sda_oe_reg <= 1'b0;
               end

               default: begin
                  state_reg  <= ST_IDLE;
                  sda_oe_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   // Register file: I2C write has priority over a host write to the same
   // entry; writes to different entries in the same clk both take effect.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst) begin
            regfile[i] <= 8'h00;
         end else if (i2c_we && (ptr_reg == ADDR_W'(i))) begin
            regfile[i] <= rx_byte;
         end else if (bus.host_we && (bus.host_addr == ADDR_W'(i))) begin
            regfile[i] <= bus.host_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         host_rdata_reg <= 8'h00;
      end else begin
         host_rdata_reg <= regfile[bus.host_addr];
      end
   end

   // SDA is released the moment reset is asserted, not one clk later
   assign bus.sda_oe     = sda_oe_reg & ~rst;
   assign bus.busy       = busy_reg;
   assign bus.wr_stb     = wr_stb_reg;
   assign bus.wr_addr    = wr_addr_reg;
   assign bus.wr_data    = wr_data_reg;
   assign bus.host_rdata = host_rdata_reg;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regfile
//
// Directed bench for i2c_slave_regfile. A behavioural I2C master drives the
// pads with SCL at clk/16; the host port is driven directly. Expected values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_i2c_slave_regfile;
   localparam int ADDR_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int oe_cnt   = 0;

   logic [ADDR_W-1:0] stb_addr_q [$];
   logic [7:0]        stb_data_q [$];

   i2c_slave_regfile_if #(.ADDR_W(ADDR_W)) bus ();

   assign bus.scl_i = scl_m;
   assign bus.sda_i = sda_m & ~bus.sda_oe;

   i2c_slave_regfile #(
      .SLAVE_ADDR (7'h50),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, got running, required finished");
      $fatal(1, "watchdog");
   end

   // Record every wr_stb pulse and every clk with SDA driven
   always @(negedge clk) begin
      if (bus.wr_stb) begin
         stb_addr_q.push_back(bus.wr_addr);
         stb_data_q.push_back(bus.wr_data);
      end
      if (bus.sda_oe) begin
         oe_cnt = oe_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCL period: 8 clk low (sda set 4 clk in), 8 clk high (sampled at 4).
   // With collide set, a host write of 0x77 to entry 4 is placed on exactly
   // the clk where the target commits the byte (3rd edge after SCL rises).
   task automatic i2c_bit(input logic b, input bit collide, output logic smp);
      sda_m = b;
      wait_n(4);
      scl_m = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (collide && i == 2) begin
            bus.host_we    = 1'b1;
            bus.host_addr  = 4'd4;
            bus.host_wdata = 8'h77;
         end
         if (collide && i == 3) begin
            bus.host_we = 1'b0;
         end
         if (i == 4) begin
            smp = bus.sda_i;
         end
      end
      scl_m = 1'b0;
      wait_n(4);
   endtask

   task automatic i2c_start;
      sda_m = 1'b1;
      wait_n(4);
      scl_m = 1'b1;
      wait_n(4);
      sda_m = 1'b0;
      wait_n(4);
      scl_m = 1'b0;
      wait_n(4);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0;
      wait_n(4);
      scl_m = 1'b1;
      wait_n(4);
      sda_m = 1'b1;
      wait_n(8);
   endtask

   task automatic i2c_write_byte(input logic [7:0] data, input bit collide, output bit ack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         i2c_bit(data[i], collide && (i == 0), s);
      end
      i2c_bit(1'b1, 1'b0, s);
      ack = (s == 1'b0);
   endtask

   task automatic i2c_read_byte(input bit mack, output logic [7:0] data);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         i2c_bit(1'b1, 1'b0, s);
         data[i] = s;
      end
      i2c_bit(mack ? 1'b0 : 1'b1, 1'b0, s);
   endtask

   task automatic host_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      bus.host_we    = 1'b1;
      bus.host_addr  = a;
      bus.host_wdata = d;
      @(negedge clk);
      bus.host_we = 1'b0;
   endtask

   task automatic host_read(input logic [ADDR_W-1:0] a, output logic [7:0] d);
      bus.host_addr = a;
      @(negedge clk);
      d = bus.host_rdata;
   endtask

   initial begin
      bit          ack;
      logic [7:0]  rd;
      int          oe_before;
      int          stb_before;

      bus.host_we    = 1'b0;
      bus.host_addr  = '0;
      bus.host_wdata = 8'h00;

      // Reset state
      wait_n(4);
      chk("rst_sda_oe", bus.sda_oe, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_wr_stb", bus.wr_stb, 0);
      chk("rst_wr_addr", bus.wr_addr, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      chk("rst_host_rdata", bus.host_rdata, 0);
      rst = 1'b0;
      wait_n(4);
      $display("txn reset: done");

      // Write 0x11, 0x22 from pointer 3; host collides on entry 4
      i2c_start();
      i2c_write_byte(8'hA0, 1'b0, ack);
      chk("wr_ack_addr", ack, 1);
      chk("wr_busy_high", bus.busy, 1);
      i2c_write_byte(8'h03, 1'b0, ack);
      chk("wr_ack_ptr", ack, 1);
      i2c_write_byte(8'h11, 1'b0, ack);
      chk("wr_ack_d0", ack, 1);
      i2c_write_byte(8'h22, 1'b1, ack);
      chk("wr_ack_d1", ack, 1);
      i2c_stop();
      chk("wr_busy_low", bus.busy, 0);
      chk("wr_stb_count", stb_addr_q.size(), 2);
      chk("wr_stb0_addr", stb_addr_q[0], 3);
      chk("wr_stb0_data", stb_data_q[0], 8'h11);
      chk("wr_stb1_addr", stb_addr_q[1], 4);
      chk("wr_stb1_data", stb_data_q[1], 8'h22);
      host_read(4'd3, rd);
      chk("wr_reg3", rd, 8'h11);
      host_read(4'd4, rd);
      chk("collide_reg4", rd, 8'h22);
      $display("txn write ptr=3 data=11,22: done");

      // Combined read: pointer 3, repeated START, read two bytes
      i2c_start();
      i2c_write_byte(8'hA0, 1'b0, ack);
      chk("rd_ack_waddr", ack, 1);
      i2c_write_byte(8'h03, 1'b0, ack);
      chk("rd_ack_ptr", ack, 1);
      i2c_start();
      i2c_write_byte(8'hA1, 1'b0, ack);
      chk("rd_ack_raddr", ack, 1);
      i2c_read_byte(1'b1, rd);
      chk("rd_byte0", rd, 8'h11);
      i2c_read_byte(1'b0, rd);
      chk("rd_byte1", rd, 8'h22);
      i2c_stop();
      chk("rd_no_stb", stb_addr_q.size(), 2);
      chk("rd_busy_low", bus.busy, 0);
      $display("txn read ptr=3 -> 11,22: done");

      // Pointer wrap from 15 to 0
      i2c_start();
      i2c_write_byte(8'hA0, 1'b0, ack);
      i2c_write_byte(8'h0F, 1'b0, ack);
      i2c_write_byte(8'hAA, 1'b0, ack);
      i2c_write_byte(8'hBB, 1'b0, ack);
      i2c_write_byte(8'hCC, 1'b0, ack);
      chk("wrap_ack_last", ack, 1);
      i2c_stop();
      chk("wrap_stb_count", stb_addr_q.size(), 5);
      chk("wrap_stb2_addr", stb_addr_q[2], 15);
      chk("wrap_stb3_addr", stb_addr_q[3], 0);
      chk("wrap_stb4_addr", stb_addr_q[4], 1);
      host_read(4'd15, rd);
      chk("wrap_reg15", rd, 8'hAA);
      host_read(4'd0, rd);
      chk("wrap_reg0", rd, 8'hBB);
      host_read(4'd1, rd);
      chk("wrap_reg1", rd, 8'hCC);
      $display("txn write ptr=F data=AA,BB,CC: done");

      // Address mismatch: target must stay off the bus
      oe_before  = oe_cnt;
      stb_before = stb_addr_q.size();
      i2c_start();
      i2c_write_byte(8'hB0, 1'b0, ack);
      chk("mis_nack_addr", ack, 0);
      i2c_write_byte(8'h55, 1'b0, ack);
      chk("mis_nack_data", ack, 0);
      i2c_stop();
      chk("mis_oe_clks", oe_cnt - oe_before, 0);
      chk("mis_no_stb", stb_addr_q.size(), stb_before);
      host_read(4'd3, rd);
      chk("mis_reg3", rd, 8'h11);
      host_read(4'd5, rd);
      chk("mis_reg5", rd, 8'h00);
      $display("txn mismatch addr=58: done");

      // General call
      i2c_start();
      i2c_write_byte(8'h00, 1'b0, ack);
`ifdef I2C_SLAVE_GCALL_EN
      chk("gc_ack", ack, 1);
`else
      chk("gc_ack", ack, 0);
`endif
      i2c_write_byte(8'h02, 1'b0, ack);
      i2c_write_byte(8'h5A, 1'b0, ack);
      i2c_stop();
      host_read(4'd2, rd);
`ifdef I2C_SLAVE_GCALL_EN
      chk("gc_reg2", rd, 8'h5A);
`else
      chk("gc_reg2", rd, 8'h00);
`endif
      $display("txn general call ptr=2 data=5A: done");

      // Reset while the target is driving a read bit (entry 5 = 0x00)
      i2c_start();
      i2c_write_byte(8'hA0, 1'b0, ack);
      i2c_write_byte(8'h05, 1'b0, ack);
      i2c_start();
      i2c_write_byte(8'hA1, 1'b0, ack);
      chk("rr_ack_raddr", ack, 1);
      chk("rr_oe_before", bus.sda_oe, 1);
      rst = 1'b1;
      #1;
      chk("rr_oe_immediate", bus.sda_oe, 0);
      @(negedge clk);
      chk("rr_oe_next", bus.sda_oe, 0);
      chk("rr_busy", bus.busy, 0);
      @(negedge clk);
      rst = 1'b0;
      sda_m = 1'b1;
      scl_m = 1'b1;
      wait_n(8);
      host_read(4'd3, rd);
      chk("rr_reg3_cleared", rd, 8'h00);
      host_write(4'd0, 8'h3C);
      i2c_start();
      i2c_write_byte(8'hA1, 1'b0, ack);
      chk("rr_ack_after", ack, 1);
      i2c_read_byte(1'b0, rd);
      chk("rr_ptr_zero", rd, 8'h3C);
      i2c_stop();
      $display("txn reset mid-read then read ptr=0: done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised I2C target with an internal byte-wide register file, oversampled from a system clock. It supports multi-byte writes and reads with pointer auto-increment, repeated START, address filtering and master NACK handling. It sits between the open-drain I2C pads and local logic, which reads and writes the same register file through a host port.

## Interface
Parameters:
- SLAVE_ADDR, 7'h50, 7-bit target address
- ADDR_W, 4, register pointer width; DEPTH = 2**ADDR_W bytes

Ports:
- clk  in  1  system clock, at least 16x SCL frequency
- rst  in  1  reset; synchronous, active-high
- scl_i  in  1  SCL pad input, asynchronous
- sda_i  in  1  SDA pad input, asynchronous
- sda_oe  out  1  1 = drive SDA low; pad is open-drain
- busy  out  1  high from an addressed START until STOP or address mismatch
- host_we  in  1  host write enable
- host_addr  in  ADDR_W  host read/write address
- host_wdata  in  8  host write data
- host_rdata  out  8  registered read of regfile[host_addr]
- wr_stb  out  1  one-clk pulse per byte written over I2C
- wr_addr  out  ADDR_W  register index of that byte
- wr_data  out  8  value of that byte

## Operation
- Input conditioning:
  - scl_i and sda_i pass through 2-flop synchronisers.
  - A third flop stage gives edge detect: scl_rise, scl_fall.
- Bus conditions (evaluated only while synchronised SCL is high):
  - START = SDA falling.
  - STOP = SDA rising.
- A START in any state, including mid-byte (repeated START):
  - bit counter cleared;
  - state = ADDR;
  - sda_oe = 0.
- A STOP in any state: state = IDLE, busy = 0, sda_oe = 0.
- FSM states and transitions:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits MSB-first on scl_rise. The 8th bit is R/W.
    - On a match, go to ADDR_ACK.
    - On a mismatch, go to IGNORE.
  - IGNORE: releases SDA and clears busy; waits for START or STOP.
  - ADDR_ACK: drives ACK for one SCL period.
    - R/W = 0: go to PTR.
    - R/W = 1: go to READ; byte source = regfile[ptr].
  - PTR: first written byte loads ptr; then PTR_ACK, then WRITE.
  - WRITE: each received byte is stored and acknowledged in WRITE_ACK.
    - Byte goes to regfile[ptr].
    - wr_stb pulses with wr_addr = ptr and wr_data = byte.
    - ptr then increments.
  - READ: shifts regfile[ptr] MSB-first, then moves to MACK.
  - MACK: samples the master ACK bit on scl_rise.
    - ACK (0): ptr increments, next byte is loaded, go to READ.
    - NACK (1): go to IGNORE (SDA released until STOP/START).
- Pointer: ptr wraps from DEPTH-1 to 0. The pointer persists across transactions, so a write-pointer-then-repeated-START-read sequence works.
- Host port:
  - host_rdata <= regfile[host_addr] every clk.
  - host_we writes regfile[host_addr].
  - If the I2C write and host write target the same address in the same clk, the I2C write wins and the host write is dropped.
  - Writes to different addresses both occur.

## Timing
- Reset values:
  - sda_oe = 0, busy = 0, wr_stb = 0, wr_addr = 0, wr_data = 0, host_rdata = 0.
  - ptr = 0, all regfile bytes = 0, state = IDLE.
- SDA sampling: data is sampled on the clk where scl_rise is asserted, which is 3 clk after the pad edge.
- SDA output changes (ACK assert/release, read bits): sda_oe is updated on the clk after scl_fall is detected. This meets I2C hold time for clk >= 16x SCL.
- ACK drive window: sda_oe = 1 from the scl_fall ending bit 8 until the next scl_fall.
- busy:
  - rises 1 clk after ADDR_ACK entry;
  - falls 1 clk after STOP detection or IGNORE entry.
- wr_stb: asserted 1 clk, on the clk after the 8th data bit's scl_rise.
- host_rdata latency: 1 clk. A host read of the address just written by I2C returns the new value from the clk after wr_stb.
- Reset mid-transfer: the next clk returns all outputs to reset values. SDA is released immediately.

## Configuration
- I2C_SLAVE_GCALL_EN defined:
  - address byte 8'h00 (general call, write) is ACKed;
  - the transaction then proceeds exactly as a normal write (PTR, WRITE);
  - address 8'h01 is not ACKed (→ IGNORE).
- Undefined: 8'h00 is treated as a normal mismatch (NACK, IGNORE).

## Test plan
- Write: START, 0xA0, 0x03, 0x11, 0x22, STOP.
  - ACK on all bytes.
  - regfile[3] = 0x11, regfile[4] = 0x22.
  - Two wr_stb pulses with wr_addr 3, 4.
  - busy = 0 after STOP.
- Combined read: START, 0xA0, 0x03, repeated START, 0xA1, master ACK, master NACK, STOP.
  - SDA returns 0x11 then 0x22.
  - No wr_stb for the pointer byte.
- Wrap: ADDR_W = 4, write pointer 0x0F then 3 bytes 0xAA, 0xBB, 0xCC.
  - regfile[15] = 0xAA, regfile[0] = 0xBB, regfile[1] = 0xCC.
- Mismatch: START, 0xB0, 0x55, STOP.
  - sda_oe stays 0 throughout.
  - No wr_stb.
  - regfile unchanged.
- Collision and reset:
  - host_we to address 4 with 0x77 in the same clk as an I2C write of 0x22 to address 4: regfile[4] = 0x22.
  - rst asserted mid-READ: sda_oe = 0 next clk and ptr = 0.
- General call: 0x00 then 0x02, 0x5A.
  - With I2C_SLAVE_GCALL_EN: ACK, regfile[2] = 0x5A.
  - Without it: NACK, no write.
